// File: rtl/multiplier_controller_tainttrack1bit.sv
// Control FSM for a shift-and-add sequential multiplier with 1-bit taint
// tracking. Walks the multiplier bits LSB first, issuing add/shift strobes
// to the datapath, and carries a sticky taint bit that marks every control
// output once any tainted input has influenced the control flow.
module multiplier_controller_tainttrack1bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic             multiplierReg_t,
  output logic             mrld,
  output logic             mrld_t,
  output logic             mdld,
  output logic             mdld_t,
  output logic             rsclear,
  output logic             rsclear_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsshr,
  output logic             rsshr_t,
  output logic             busy,
  output logic             done,
  output logic             done_t
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ADD,
    SHIFT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          taint_q, taint_d;

  logic mrld_q, mdld_q, rsclear_q, rsload_q, rsshr_q, busy_q, done_q;

  // Next-state, bit counter and sticky taint absorption.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    taint_d = taint_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          taint_d = taint_q | start_t;
        end
      end
      LOAD: begin
        state_d = CHECK;
        cnt_d   = '0;
      end
      CHECK: begin
        // The branch depends on multiplier data, so its taint sticks.
        taint_d = taint_q | multiplierReg_t;
        state_d = multiplierReg[cnt_q] ? ADD : SHIFT;
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = CHECK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; Moore outputs are registered by decoding the next state,
  // which keeps them aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      taint_q   <= 1'b0;
      mrld_q    <= 1'b0;
      mdld_q    <= 1'b0;
      rsclear_q <= 1'b0;
      rsload_q  <= 1'b0;
      rsshr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      taint_q   <= taint_d;
      mrld_q    <= (state_d == LOAD);
      mdld_q    <= (state_d == LOAD);
      rsclear_q <= (state_d == LOAD);
      rsload_q  <= (state_d == ADD);
      rsshr_q   <= (state_d == SHIFT);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign mrld    = mrld_q;
  assign mdld    = mdld_q;
  assign rsclear = rsclear_q;
  assign rsload  = rsload_q;
  assign rsshr   = rsshr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Every control-output taint follows the sticky taint, asserted or not.
  assign mrld_t    = taint_q;
  assign mdld_t    = taint_q;
  assign rsclear_t = taint_q;
  assign rsload_t  = taint_q;
  assign rsshr_t   = taint_q;
  assign done_t    = taint_q;

endmodule

// File: tb/tb_multiplier_controller_tainttrack1bit.sv
// Directed bench for the taint-tracking multiplier controller, with a small
// shift-and-add datapath attached so the resulting product can be checked.
module tb_multiplier_controller_tainttrack1bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       start_t = 1'b0;
  logic [3:0] mr_q = '0;
  logic       mr_taint = 1'b0;
  logic       mrld, mrld_t, mdld, mdld_t, rsclear, rsclear_t;
  logic       rsload, rsload_t, rsshr, rsshr_t, busy, done, done_t;

  logic [3:0] mr_in = '0;
  logic [3:0] md_in = '0;
  logic [3:0] md_q = '0;
  logic [8:0] rs_q = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multiplier_controller_tainttrack1bit #(.WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_t        (start_t),
    .multiplierReg  (mr_q),
    .multiplierReg_t(mr_taint),
    .mrld           (mrld),
    .mrld_t         (mrld_t),
    .mdld           (mdld),
    .mdld_t         (mdld_t),
    .rsclear        (rsclear),
    .rsclear_t      (rsclear_t),
    .rsload         (rsload),
    .rsload_t       (rsload_t),
    .rsshr          (rsshr),
    .rsshr_t        (rsshr_t),
    .busy           (busy),
    .done           (done),
    .done_t         (done_t)
  );

  // Shift-and-add datapath: add into the upper half, shift right each step.
  always @(posedge clk) begin
    if (mrld) mr_q <= mr_in;
    if (mdld) md_q <= md_in;
    if (rsclear)     rs_q <= '0;
    else if (rsload) rs_q[8:4] <= rs_q[8:4] + {1'b0, md_q};
    else if (rsshr)  rs_q <= rs_q >> 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return {25'd0, mrld, mdld, rsclear, rsload, rsshr, busy, done};
  endfunction

  function automatic logic [31:0] taint_vec();
    return {26'd0, mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t, done_t};
  endfunction

  // Called at #1 after a posedge; leaves the bench at #1 after a posedge.
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    start_t = 1'b0;
    mr_taint = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset%0d_ctl", i), ctl_vec(), 32'd0);
      check($sformatf("reset%0d_taint", i), taint_vec(), 32'd0);
    end
    rst = 1'b0;
  endtask

  // One multiply. lmask/smask: cycles with rsload/rsshr; ign: extra start
  // pulses to be ignored; rst_at>0 asserts rst during that cycle.
  task automatic run(input string nm, input logic [3:0] mr, input logic [3:0] md,
                     input logic st_t, input logic mt,
                     input logic [31:0] lmask, input logic [31:0] smask,
                     input logic [31:0] ign, input int done_c, input int rst_at,
                     input logic [7:0] prod);
    logic [31:0] exp;
    logic        et;
    mr_in = mr;
    md_in = md;
    for (int c = 0; c <= done_c + 1; c++) begin
      start    = (c == 0) || ign[c];
      start_t  = (c == 0) ? st_t : 1'b0;
      mr_taint = mt && (c >= 2);
      rst      = (rst_at > 0) && (c == rst_at);
      @(negedge clk);
      if ((rst_at > 0) && (c == rst_at + 1)) begin
        check($sformatf("%s_rst_ctl", nm), ctl_vec(), 32'd0);
        check($sformatf("%s_rst_taint", nm), taint_vec(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        mr_taint = 1'b0;
        for (int k = 0; k < 14; k++) begin
          @(negedge clk);
          check($sformatf("%s_nodone%0d", nm, k), {30'd0, busy, done}, 32'd0);
          @(posedge clk); #1;
        end
        return;
      end
      exp = {25'd0, (c == 1), (c == 1), (c == 1), lmask[c], smask[c],
             (c >= 1) && (c <= done_c), (c == done_c)};
      et  = (st_t && c >= 1) || (mt && c >= 3);
      check($sformatf("%s_c%0d_ctl", nm, c), ctl_vec(), exp);
      check($sformatf("%s_c%0d_taint", nm, c), taint_vec(), {26'd0, {6{et}}});
      if (c == done_c + 1)
        check($sformatf("%s_product", nm), {24'd0, rs_q[7:0]}, {24'd0, prod});
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    run("m5x3", 4'd5, 4'd3, 1'b0, 1'b0, 32'h0000_0108, 32'h0000_0A50,
        32'd0, 12, 0, 8'd15);
    run("m0x9", 4'd0, 4'd9, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_02A8,
        32'd0, 10, 0, 8'd0);
    run("m15x15", 4'd15, 4'd15, 1'b0, 1'b0, 32'h0000_1248, 32'h0000_2490,
        32'h0000_1008, 14, 0, 8'd225);

    // Abort mid-operation, then a full fresh multiply.
    run("abort", 4'd5, 4'd3, 1'b0, 1'b0, 32'h0000_0108, 32'h0000_0A50,
        32'd0, 12, 5, 8'd15);
    run("m6x5", 4'd6, 4'd5, 1'b0, 1'b0, 32'h0000_0120, 32'h0000_0A48,
        32'd0, 12, 0, 8'd30);

    // Data taint absorbed at the first CHECK, sticky in IDLE until reset.
    run("mrt", 4'd5, 4'd3, 1'b0, 1'b1, 32'h0000_0108, 32'h0000_0A50,
        32'd0, 12, 0, 8'd15);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("sticky%0d", k), taint_vec(), 32'h3F);
      @(posedge clk); #1;
    end
    do_reset();

    // Start taint visible from LOAD onward.
    run("stt", 4'd2, 4'd7, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0548,
        32'd0, 11, 0, 8'd14);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/multiplier_controller_tainttrack1bit.md
Name: multiplier_controller_tainttrack1bit

Overview:
Control FSM for the shift-and-add sequential multiplier, with 1-bit taint tracking. It sits directly upstream of the multiplier datapath and drives mrld, mdld, rsclear, rsload and rsshr, each with its taint bit. It reads multiplierReg and multiplierReg_t back from the datapath to make its add/skip decision on each bit. It signals completion to the external requester with done and done_t.

Parameters:
WIDTH, 4, operand width; must match the datapath WIDTH; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin a multiply; sampled only in IDLE.
start_t  input  1  taint of start.
multiplierReg  input  WIDTH  multiplier register fed back from the datapath.
multiplierReg_t  input  1  taint of multiplierReg.
mrld / mrld_t  output  1 / 1  load multiplier register, and its taint.
mdld / mdld_t  output  1 / 1  load multiplicand register, and its taint.
rsclear / rsclear_t  output  1 / 1  clear running sum, and its taint.
rsload / rsload_t  output  1 / 1  add multiplicand into running sum, and its taint.
rsshr / rsshr_t  output  1 / 1  shift running sum right by 1, and its taint.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when the product is valid.
done_t  output  1  taint of done.

Behaviour:
- States: IDLE, LOAD, CHECK, ADD, SHIFT, DONE. Internal bit counter cnt has width $clog2(WIDTH). Internal taint bit state_t.
- Reset: rst has priority over everything, including mid-operation.
  - Next state IDLE, cnt=0, state_t=0.
  - Every output and every *_t reads 0 in the cycle after the rst edge.
- Outputs are Moore, decoded from the state register only, with no combinational path from any input:
  - LOAD: mrld=mdld=rsclear=1.
  - ADD: rsload=1.
  - SHIFT: rsshr=1.
  - DONE: done=1.
  - All other control outputs 0 in every state.
  - rsload and rsshr are never high together.
- Transitions:
  - IDLE: start=1 -> LOAD; otherwise stay IDLE.
  - LOAD -> CHECK, with cnt <= 0.
  - CHECK: multiplierReg[cnt]=1 -> ADD; otherwise -> SHIFT.
  - ADD -> SHIFT.
  - SHIFT: cnt==WIDTH-1 -> DONE; otherwise cnt <= cnt+1 and -> CHECK.
  - DONE -> IDLE, unconditionally.
- Start handling: start is ignored in every state other than IDLE. No queuing; a start seen in DONE is dropped.
- Latency: take the cycle in which start=1 is sampled in IDLE as cycle 0.
  - LOAD occupies cycle 1.
  - done is high in cycle 2 + 2*WIDTH + popcount(multiplier).
  - IDLE in the following cycle; earliest next start is sampled there.
- Datapath contract: multiplierReg is valid from cycle 2 onward, because mrld is asserted in LOAD. After WIDTH add/shift steps the datapath holds product = multiplier*multiplicand in its low 2*WIDTH bits.
- Taint rules (state_t is sticky, cleared only by rst):
  - IDLE with start=1: state_t <= state_t | start_t.
  - CHECK: state_t <= state_t | multiplierReg_t, because the branch depends on the data.
  - Every control-output taint (mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t, done_t) equals state_t in every cycle, whether or not the matching output is asserted.
  - A taint absorbed at a CHECK edge is visible from the next cycle onward.

Test Plan:
- Reset: hold rst 2 cycles from random state -> all outputs and all *_t = 0; busy=0; start in the first cycle after reset is accepted (LOAD next cycle).
- WIDTH=4, multiplier=5, multiplicand=3, one-cycle start, all taints 0, datapath attached -> cycle 1: mrld=mdld=rsclear=1; rsload in cycles 3 and 8; rsshr in cycles 4, 6, 9, 11; done in cycle 12; product=15; all *_t=0.
- multiplier=0, multiplicand=9 -> rsload never asserted; 4 rsshr pulses; done in cycle 10; product=0.
- multiplier=15, multiplicand=15 -> 4 rsload pulses; done in cycle 14; product=225; start pulses in cycles 3 and 12 ignored.
- Taint: multiplier=5 with multiplierReg_t=1 after load -> all *_t=0 through cycle 2, =1 from cycle 3 and at done (cycle 12), still 1 in IDLE until rst. Separately, start_t=1 with start -> mrld_t=mdld_t=rsclear_t=1 in cycle 1.
- Reset mid-operation: rst=1 in cycle 5 of a multiply -> cycle 6: IDLE, all outputs and *_t = 0, no done pulse; a new start then runs a full, correct multiply.
